// File: rtl/sha1_seq.sv
// -----------------------------------------------------------------------------
// sha1_seq: SHA-1 message sequencer.
//
// Accepts a message as a stream of 64-bit big-endian words, writes each word
// into an external 8-word hash register bank, appends SHA-1 padding (0x80
// marker, zero fill and 64-bit big-endian bit count), kicks the hash core once
// per completed 512-bit block and hands the final digest out on a
// valid/ready port.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   msg_valid_i/msg_ready_o            message word handshake
//   msg_data_i                         message word, byte 0 in bits 63:56
//   msg_last_i/msg_nbytes_i            final word flag / valid bytes (1..8)
//   bus_req*_o, bus_reqready_i         register bank write request
//   bus_rsperror_i                     register bank error (aborts message)
//   process_o                          one-cycle start pulse to the core
//   digest_i/digestvalid_i/digestack_o core digest and acknowledge
//   hash_o/hash_valid_o/hash_ready_i   final hash handshake
//   busy_o/error_o                     message in progress / sticky error
//
// Optional feature: define SHA1_SEQ_TIMEOUT_EN to abort with error_o when the
// core does not return a digest within 1024 cycles.
// DataWidth only supports 64.
// -----------------------------------------------------------------------------
module sha1_seq #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned AddrWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 msg_valid_i,
   output logic                 msg_ready_o,
   input  logic [DataWidth-1:0] msg_data_i,
   input  logic                 msg_last_i,
   input  logic [3:0]           msg_nbytes_i,
   output logic                 bus_reqvalid_o,
   output logic                 bus_reqwrite_o,
   output logic [AddrWidth-1:0] bus_reqaddr_o,
   output logic [DataWidth-1:0] bus_reqdata_o,
   output logic [7:0]           bus_reqstrobe_o,
   input  logic                 bus_reqready_i,
   input  logic                 bus_rsperror_i,
   output logic                 process_o,
   input  logic [159:0]         digest_i,
   input  logic                 digestvalid_i,
   output logic                 digestack_o,
   output logic [159:0]         hash_o,
   output logic                 hash_valid_o,
   input  logic                 hash_ready_i,
   output logic                 busy_o,
   output logic                 error_o
);

   typedef enum logic [2:0] {
      StIdle, StFill, StPad, StLen, StProc, StWait, StAck, StDone
   } state_e;

   state_e               state_q, state_d;
   logic [2:0]           widx_q, widx_d;
   logic [63:0]          bitcnt_q, bitcnt_d;
   logic                 req_valid_q, req_valid_d;
   logic [DataWidth-1:0] req_data_q, req_data_d;
   logic                 pad80_q, pad80_d;       // 0x80 still owed as its own word
   logic                 padding_q, padding_d;   // whole message accepted
   logic                 len_done_q, len_done_d; // length word is in this block
   logic [159:0]         digest_q, digest_d;
   logic                 error_q, error_d;
   logic                 ready_en_q;             // keeps msg_ready_o low in reset

   logic        msg_ready, accept, wr_done, wr_err, abort, tmo_hit, last_full;
   logic [6:0]  shamt;
   logic [63:0] last_word;

   // Final word: keep nbytes bytes, place 0x80 right after them, zero the rest.
   assign shamt     = {1'b0, msg_nbytes_i[2:0], 3'b000};
   assign last_full = (msg_nbytes_i >= 4'd8);
   assign last_word = last_full ? msg_data_i :
                      ((msg_data_i & ~({64{1'b1}} >> shamt)) | (64'h80 << (7'd56 - shamt)));

   assign msg_ready = ready_en_q && ((state_q == StIdle) || (state_q == StFill)) && !req_valid_q;
   assign accept    = msg_valid_i && msg_ready;
   assign wr_err    = req_valid_q && bus_rsperror_i;
   assign wr_done   = req_valid_q && bus_reqready_i && !bus_rsperror_i;
   assign abort     = wr_err || tmo_hit;

`ifdef SHA1_SEQ_TIMEOUT_EN
   logic [9:0] tmo_q, tmo_d;

   assign tmo_d   = (state_q == StWait) ? tmo_q + 10'd1 : 10'd0;
   assign tmo_hit = (state_q == StWait) && !digestvalid_i && (tmo_q == 10'h3FF);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tmo_q <= '0;
      else         tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      widx_d      = widx_q;
      bitcnt_d    = bitcnt_q;
      req_valid_d = req_valid_q;
      req_data_d  = req_data_q;
      pad80_d     = pad80_q;
      padding_d   = padding_q;
      len_done_d  = len_done_q;
      digest_d    = digest_q;
      error_d     = error_q;

      unique case (state_q)
         StIdle, StFill: begin
            if (accept) begin
               req_valid_d = 1'b1;
               req_data_d  = msg_last_i ? last_word : msg_data_i;
               error_d     = 1'b0;
               bitcnt_d    = bitcnt_q + (msg_last_i ? {57'd0, msg_nbytes_i, 3'd0} : 64'd64);
               if (msg_last_i) begin
                  padding_d = 1'b1;
                  pad80_d   = last_full;
                  state_d   = StPad;
               end else begin
                  state_d = StFill;
               end
            end else if (wr_done) begin
               req_valid_d = 1'b0;
               widx_d      = widx_q + 3'd1;
               if (widx_q == 3'd7) state_d = StProc;
            end
         end
         StPad: begin
            if (req_valid_q) begin
               if (wr_done) begin
                  req_valid_d = 1'b0;
                  widx_d      = widx_q + 3'd1;
                  if (widx_q == 3'd7) state_d = StProc;
               end
            end else begin
               req_valid_d = 1'b1;
               if (pad80_q) begin
                  req_data_d = 64'h8000_0000_0000_0000;
                  pad80_d    = 1'b0;
               end else if (widx_q == 3'd7) begin
                  req_data_d = bitcnt_q;
                  state_d    = StLen;
               end else begin
                  req_data_d = '0;
               end
            end
         end
         StLen: begin
            if (wr_done) begin
               req_valid_d = 1'b0;
               widx_d      = widx_q + 3'd1;
               len_done_d  = 1'b1;
               state_d     = StProc;
            end
         end
         StProc: state_d = StWait;
         StWait: begin
            if (digestvalid_i) begin
               digest_d = digest_i;
               state_d  = StAck;
            end
         end
         StAck: begin
            if (len_done_q)     state_d = StDone;
            else if (padding_q) state_d = StPad;
            else                state_d = StFill;
         end
         StDone: begin
            if (hash_ready_i) begin
               state_d    = StIdle;
               bitcnt_d   = '0;
               padding_d  = 1'b0;
               len_done_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Bank error or core timeout drops the message entirely.
      if (abort) begin
         state_d     = StIdle;
         req_valid_d = 1'b0;
         widx_d      = '0;
         bitcnt_d    = '0;
         pad80_d     = 1'b0;
         padding_d   = 1'b0;
         len_done_d  = 1'b0;
         error_d     = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         widx_q      <= '0;
         bitcnt_q    <= '0;
         req_valid_q <= 1'b0;
         req_data_q  <= '0;
         pad80_q     <= 1'b0;
         padding_q   <= 1'b0;
         len_done_q  <= 1'b0;
         digest_q    <= '0;
         error_q     <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         widx_q      <= widx_d;
         bitcnt_q    <= bitcnt_d;
         req_valid_q <= req_valid_d;
         req_data_q  <= req_data_d;
         pad80_q     <= pad80_d;
         padding_q   <= padding_d;
         len_done_q  <= len_done_d;
         digest_q    <= digest_d;
         error_q     <= error_d;
         ready_en_q  <= 1'b1;
      end
   end

   assign msg_ready_o     = msg_ready;
   assign bus_reqvalid_o  = req_valid_q;
   assign bus_reqwrite_o  = req_valid_q;
   assign bus_reqaddr_o   = AddrWidth'({widx_q, 3'b000});
   assign bus_reqdata_o   = req_data_q;
   assign bus_reqstrobe_o = {8{req_valid_q}};
   assign process_o       = (state_q == StProc);
   assign digestack_o     = (state_q == StAck);
   assign hash_valid_o    = (state_q == StDone);
   assign hash_o          = hash_valid_o ? digest_q : '0;
   assign busy_o          = (state_q != StIdle);
   assign error_o         = error_q;

endmodule

// File: tb/tb_sha1_seq.sv
// -----------------------------------------------------------------------------
// tb_sha1_seq: self-checking bench for sha1_seq.
// Expected bank writes come from a byte-level SHA-1 padding model and are
// queued when a message is driven; a monitor pops them as writes complete.
// A fake core answers process_o with a known digest.
// -----------------------------------------------------------------------------
module tb_sha1_seq;

   localparam int unsigned AW = 32;
   localparam logic [159:0] AbcHash = 160'hA9993E364706816ABA3E25717850C26C9CD0D89D;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          msg_valid_i = 1'b0;
   logic          msg_ready_o;
   logic [63:0]   msg_data_i = '0;
   logic          msg_last_i = 1'b0;
   logic [3:0]    msg_nbytes_i = '0;
   logic          bus_reqvalid_o, bus_reqwrite_o;
   logic [AW-1:0] bus_reqaddr_o;
   logic [63:0]   bus_reqdata_o;
   logic [7:0]    bus_reqstrobe_o;
   logic          bus_reqready_i = 1'b0;
   logic          bus_rsperror_i = 1'b0;
   logic          process_o;
   logic [159:0]  digest_i = '0;
   logic          digestvalid_i = 1'b0;
   logic          digestack_o;
   logic [159:0]  hash_o;
   logic          hash_valid_o;
   logic          hash_ready_i = 1'b0;
   logic          busy_o, error_o;

   sha1_seq #(.DataWidth(64), .AddrWidth(AW)) u_dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .msg_valid_i    (msg_valid_i),
      .msg_ready_o    (msg_ready_o),
      .msg_data_i     (msg_data_i),
      .msg_last_i     (msg_last_i),
      .msg_nbytes_i   (msg_nbytes_i),
      .bus_reqvalid_o (bus_reqvalid_o),
      .bus_reqwrite_o (bus_reqwrite_o),
      .bus_reqaddr_o  (bus_reqaddr_o),
      .bus_reqdata_o  (bus_reqdata_o),
      .bus_reqstrobe_o(bus_reqstrobe_o),
      .bus_reqready_i (bus_reqready_i),
      .bus_rsperror_i (bus_rsperror_i),
      .process_o      (process_o),
      .digest_i       (digest_i),
      .digestvalid_i  (digestvalid_i),
      .digestack_o    (digestack_o),
      .hash_o         (hash_o),
      .hash_valid_o   (hash_valid_o),
      .hash_ready_i   (hash_ready_i),
      .busy_o         (busy_o),
      .error_o        (error_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t          exp_q[$];
   logic [159:0] hash_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           proc_cnt = 0;
   int           wr_seen = 0;
   int           resp_cnt = 0;
   bit           core_en = 1'b1;
   bit           err_arm = 1'b0;
   int           err_target = 0;
   logic [159:0] cur_digest = '0;
   logic [63:0]  msg_words[32];

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_ctl"}, 160'({msg_ready_o, bus_reqvalid_o, bus_reqwrite_o, bus_reqstrobe_o,
                                  bus_reqaddr_o, process_o, digestack_o, hash_valid_o, busy_o,
                                  error_o}), 160'(0));
      check({tag, "_data"}, 160'(bus_reqdata_o), 160'(0));
      check({tag, "_hash"}, hash_o, 160'(0));
   endtask

   // Bank write monitor, process_o counter.
   initial begin
      bit  prev_proc;
      wr_t e;
      prev_proc = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_ni) begin
            if (process_o) begin
               proc_cnt++;
               check("proc_single", 160'(prev_proc), 160'(0));
            end
            prev_proc = process_o;
            if (bus_reqvalid_o && bus_reqready_i && !bus_rsperror_i) begin
               wr_seen++;
               check("wr_expected", 160'(exp_q.size() != 0), 160'(1));
               check("wr_write", 160'(bus_reqwrite_o), 160'(1));
               check("wr_strobe", 160'(bus_reqstrobe_o), 160'(8'hFF));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("wr_addr", 160'(bus_reqaddr_o), 160'(e.addr));
                  check("wr_data", 160'(bus_reqdata_o), 160'(e.data));
               end
            end
         end else begin
            prev_proc = 1'b0;
         end
      end
   end

   // Bank ready/error driver.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         bus_rsperror_i = 1'b0;
         bus_reqready_i = ($urandom_range(0, 3) != 0);
         if (err_arm && bus_reqvalid_o && (wr_seen == err_target)) begin
            bus_rsperror_i = 1'b1;
            bus_reqready_i = 1'b0;
            err_arm        = 1'b0;
         end
      end
   end

   // Fake hash core: digest differs per block so the final one is distinguishable.
   initial begin
      bit got;
      forever begin
         @(negedge clk_i);
         if (rst_ni && process_o && core_en) begin
            got = 1'b0;
            repeat (3) @(posedge clk_i);
            #1;
            digestvalid_i = 1'b1;
            digest_i      = cur_digest ^ 160'(resp_cnt);
            resp_cnt++;
            for (int k = 0; k < 20 && !got; k++) begin
               @(negedge clk_i);
               if (digestack_o) got = 1'b1;
            end
            check("digestack", 160'(got), 160'(1));
            @(posedge clk_i);
            #1;
            digestvalid_i = 1'b0;
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic put_word(input logic [63:0] d, input bit last, input logic [3:0] nb);
      int cyc = 0;
      @(posedge clk_i);
      #1;
      msg_valid_i  = 1'b1;
      msg_data_i   = d;
      msg_last_i   = last;
      msg_nbytes_i = nb;
      @(negedge clk_i);
      while (!msg_ready_o && cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
      end
      check("msg_accept", 160'(msg_ready_o), 160'(1));
   endtask

   task automatic wait_done(input int blocks, input int proc_base);
      int           cyc = 0;
      logic [159:0] eh;
      while (!hash_valid_o && cyc < 5000) begin
         @(negedge clk_i);
         cyc++;
      end
      check("done_reached", 160'(hash_valid_o), 160'(1));
      eh = (hash_q.size() != 0) ? hash_q.pop_front() : '0;
      check("hash", hash_o, eh);
      check("wr_all_done", 160'(exp_q.size()), 160'(0));
      check("blocks", 160'(proc_cnt - proc_base), 160'(blocks));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         check("hash_hold", hash_o, eh);
         check("hold_flags", 160'({hash_valid_o, msg_ready_o, busy_o}), 160'(3'b101));
      end
      @(posedge clk_i);
      #1;
      hash_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      hash_ready_i = 1'b0;
      @(negedge clk_i);
      check("done_exit", 160'({hash_valid_o, busy_o, msg_ready_o}), 160'(3'b001));
   endtask

   // Model: byte-level SHA-1 padding of the message in msg_words[0..nw-1].
   task automatic send_msg(input int nw, input logic [3:0] nb, input logic [159:0] dig,
                           input bit expect_done);
      logic [7:0]  bytes[$];
      logic [63:0] bits;
      int          cnt, blocks, proc_base;
      wr_t         w;
      for (int i = 0; i < nw; i++) begin
         cnt = (i == nw - 1) ? int'(nb) : 8;
         for (int b = 0; b < cnt; b++) bytes.push_back(msg_words[i][63-8*b -: 8]);
      end
      bits = 64'(bytes.size()) * 64'd8;
      bytes.push_back(8'h80);
      while (bytes.size() % 64 != 56) bytes.push_back(8'h00);
      for (int b = 7; b >= 0; b--) bytes.push_back(bits[8*b +: 8]);
      blocks = bytes.size() / 64;
      for (int i = 0; i < bytes.size() / 8; i++) begin
         w.addr = 32'((i % 8) * 8);
         for (int b = 0; b < 8; b++) w.data[63-8*b -: 8] = bytes[8*i+b];
         exp_q.push_back(w);
      end
      cur_digest = dig;
      resp_cnt   = 0;
      proc_base  = proc_cnt;
      if (expect_done) hash_q.push_back(dig ^ 160'(blocks - 1));
      for (int i = 0; i < nw; i++) put_word(msg_words[i], (i == nw - 1), nb);
      @(posedge clk_i);
      #1;
      msg_valid_i = 1'b0;
      if (expect_done) wait_done(blocks, proc_base);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      check_outs_zero(tag);
      @(negedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic wait_proc(input int pb);
      int cyc = 0;
      while (proc_cnt == pb && cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
      end
      check("wait_entered", 160'(proc_cnt - pb), 160'(1));
   endtask

   initial begin
      int pb;
      // Reset values and msg_ready_o one cycle after release.
      repeat (3) @(negedge clk_i);
      check_outs_zero("reset");
      #1;
      rst_ni = 1'b1;
      #1;
      check("rdy_at_release", 160'(msg_ready_o), 160'(0));
      @(negedge clk_i);
      check("rdy_after_edge", 160'(msg_ready_o), 160'(1));

      // "abc"
      msg_words[0] = 64'h6162_6300_0000_0000;
      send_msg(1, 4'd3, AbcHash, 1'b1);

      // Eight full words: 0x80 goes into its own word of a second block.
      for (int i = 0; i < 8; i++) msg_words[i] = {$urandom, $urandom};
      send_msg(8, 4'd8, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);

      // Seven full words plus two bytes: 0x80 lands at widx 7.
      for (int i = 0; i < 8; i++) msg_words[i] = {$urandom, $urandom};
      send_msg(8, 4'd2, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);

      // Random lengths, junk beyond nbytes in the final word.
      for (int t = 0; t < 4; t++) begin
         int nw;
         nw = $urandom_range(1, 20);
         for (int i = 0; i < nw; i++) msg_words[i] = {$urandom, $urandom};
         send_msg(nw, 4'($urandom_range(1, 8)),
                  {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
      end

      // Bank error on the third write.
      for (int i = 0; i < 3; i++) msg_words[i] = {$urandom, $urandom};
      exp_q.push_back('{addr: 32'd0, data: msg_words[0]});
      exp_q.push_back('{addr: 32'd8, data: msg_words[1]});
      err_target = wr_seen + 2;
      err_arm    = 1'b1;
      pb         = proc_cnt;
      for (int i = 0; i < 3; i++) put_word(msg_words[i], 1'b0, 4'd8);
      @(posedge clk_i);
      #1;
      msg_valid_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("err_next_cycle", 160'({error_o, busy_o, bus_reqvalid_o}), 160'(3'b100));
      repeat (20) @(negedge clk_i);
      check("err_sticky", 160'(error_o), 160'(1));
      check("err_no_proc", 160'(proc_cnt - pb), 160'(0));
      check("err_writes", 160'(exp_q.size()), 160'(0));
      err_arm = 1'b0;

      // Next message clears the error.
      msg_words[0] = 64'h6162_6300_0000_0000;
      send_msg(1, 4'd3, AbcHash, 1'b1);
      check("err_cleared", 160'(error_o), 160'(0));

      // Reset while waiting for the core.
      core_en = 1'b0;
      pb      = proc_cnt;
      send_msg(1, 4'd3, AbcHash, 1'b0);
      wait_proc(pb);
      repeat (5) @(negedge clk_i);
      check("wait_busy", 160'({busy_o, exp_q.size() == 0}), 160'(2'b11));
      do_reset("rst_wait");
      repeat (20) @(negedge clk_i);
      check("rst_no_proc", 160'(proc_cnt - pb), 160'(1));
      check("rst_idle", 160'({busy_o, error_o, msg_ready_o, bus_reqvalid_o}), 160'(4'b0010));

      // Core never answers.
      pb = proc_cnt;
      send_msg(1, 4'd3, AbcHash, 1'b0);
      wait_proc(pb);
`ifdef SHA1_SEQ_TIMEOUT_EN
      repeat (1024) @(negedge clk_i);
      check("tmo_early", 160'(error_o), 160'(0));
      @(negedge clk_i);
      check("tmo_fire", 160'({error_o, busy_o}), 160'(2'b10));
`else
      repeat (1100) @(negedge clk_i);
      check("wait_hold", 160'({error_o, busy_o}), 160'(2'b01));
      do_reset("rst_hold");
`endif
      core_en = 1'b1;

      // Recovery.
      msg_words[0] = 64'h0123_4567_89AB_CDEF;
      msg_words[1] = 64'hFEDC_BA98_7654_3210;
      send_msg(2, 4'd5, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
      check("final_error", 160'(error_o), 160'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
